// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory and
// write-back steps, driving datapath selects and write enables per state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUop,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;

  state_t state_q, state_d;
  logic   mem_read_c, mem_write_c, ir_write_c, pc_en_c, reg_write_c, illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_en_c     = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    i_or_d      = 1'b0;
    pc_source   = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ALUop       = 2'b00;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:         state_d = S_EXEC;
          OP_ADDI:      state_d = S_IEXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_JMP:       state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b11;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b01;
        pc_source = 2'b01;
        pc_en_c   = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en_c   = 1'b1;
        state_d   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = 2'b10;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset holds state at FETCH, which would otherwise request a read; gate
  // every request/write strobe with rst_n so nothing escapes during reset.
  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_en     = pc_en_c     & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign illegal   = illegal_c   & rst_n;
  assign state     = state_q;

endmodule
